uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_if.sv | 27 ++
 rtl/uart_tx_feeder.sv | 119 +++++++++++
 tb/tb_uart_tx_feeder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Host-side bundle for the UART transmit feeder: byte writes and transmit
// enable in, FIFO status and UART start strobe/data out.
interface uart_tx_feeder_if #(
  parameter int DEPTH = 8
) ();
  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     tx_en;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     wr_drop;
  logic                     valid;
  logic [7:0]               data_in;

  // Host / stimulus side
  modport master (
    output wr_en, wr_data, tx_en,
    input  full, empty, count, wr_drop, valid, data_in
  );

  // Feeder side
  modport slave (
    input  wr_en, wr_data, tx_en,
    output full, empty, count, wr_drop, valid, data_in
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// UART transmit feeder: a circular byte FIFO drained one byte per frame slot.
// Each pop presents the byte on data_in and raises valid for VALID_CYCLES,
// then waits out the rest of the FRAME_CYCLES slot before the next pop.
module uart_tx_feeder #(
  parameter int DEPTH        = 8,
  parameter int VALID_CYCLES = 20832,
  parameter int FRAME_CYCLES = 114576
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_feeder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_drop;
  logic [7:0]    r_data;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Status flags come straight from the registered count so they always agree
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // Writes are judged against the pre-edge fullness; a same-cycle pop does not rescue them
  assign w_push  = bus.wr_en && !w_full;

  assign bus.full    = w_full;
  assign bus.empty   = w_empty;
  assign bus.count   = r_count;
  assign bus.wr_drop = r_drop;
  assign bus.valid   = (r_state == SEND);
  assign bus.data_in = r_data;

  // Storage array: no reset needed, stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.wr_data;
  end

  // FIFO pointers, occupancy, drop pulse and the held output byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_drop <= bus.wr_en && w_full;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_data <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer state and slot counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state: pop on IDLE when enabled, strobe in SEND, fill the slot in WAIT
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tx_en && !w_empty) begin
          w_pop        = 1'b1;
          w_cnt_next   = '0;
          w_state_next = SEND;
        end
      end
      SEND: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CW'(VALID_CYCLES - 1)) w_state_next = WAIT;
      end
      WAIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CW'(FRAME_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: a queue-based model predicts FIFO
// occupancy, drops and frame slots; a monitor checks every cycle and pops
// expected bytes whenever the DUT raises valid.
module tb_uart_tx_feeder;

  localparam int DEPTH = 4;
  localparam int VC    = 2;
  localparam int FC    = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(
    .DEPTH(DEPTH), .VALID_CYCLES(VC), .FRAME_CYCLES(FC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int frames = 0;

  // Reference model: byte queue plus remaining edges in the current frame slot
  byte unsigned mq[$];
  byte unsigned scb[$];
  int           busy = 0;
  byte unsigned m_data = 8'h00;
  bit           m_drop = 1'b0;
  bit           m_full;
  bit           m_pop;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    scb.delete();
    busy   = 0;
    m_data = 8'h00;
    m_drop = 1'b0;
  endtask

  // Model advances on every clock edge using the inputs sampled there
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (busy == 0) && bus.tx_en && (mq.size() != 0);
      m_drop = bus.wr_en && m_full;
      if (busy > 0) busy--;
      if (m_pop) begin
        m_data = mq.pop_front();
        busy   = FC;
        scb.push_back(m_data);
      end
      if (bus.wr_en && !m_full) mq.push_back(bus.wr_data);
    end
  end

  // Monitor: per-cycle status plus byte scoreboard on each valid rise
  bit prev_v = 1'b0;
  byte unsigned exp_b;
  initial forever begin
    @(posedge clk);
    #1;
    check("valid",   bus.valid,   (busy > FC - VC) ? 1 : 0);
    check("data_in", bus.data_in, m_data);
    check("count",   bus.count,   mq.size());
    check("empty",   bus.empty,   (mq.size() == 0) ? 1 : 0);
    check("full",    bus.full,    (mq.size() == DEPTH) ? 1 : 0);
    check("wr_drop", bus.wr_drop, m_drop);
    if (bus.valid && !prev_v) begin
      if (scb.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        exp_b = scb.pop_front();
        check("frame_byte", bus.data_in, exp_b);
        frames++;
        $display("frame %0d: byte %02h expected %02h", frames, bus.data_in, exp_b);
      end
    end
    prev_v = bus.valid;
  end

  task automatic step(input bit we, input byte unsigned d, input bit te);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.tx_en   = te;
  endtask

  task automatic drain();
    int n = 0;
    while (!(mq.size() == 0 && busy == 0) && n < 200) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("drain_timeout", (n < 200) ? 1 : 0, 1);
    step(1'b0, 8'h00, 1'b1);
    check("scoreboard_empty", scb.size(), 0);
  endtask

  initial begin
    int n;
    int written;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_en   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", bus.valid, 0);
    check("rst_data",  bus.data_in, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full",  bus.full, 0);
    check("rst_drop",  bus.wr_drop, 0);
    reset_n = 1'b1;

    // Single byte
    step(1'b1, 8'hA5, 1'b1);
    repeat (9) step(1'b0, 8'h00, 1'b1);
    drain();

    // Back-to-back
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    drain();

    // Overflow with transmit held off
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("ovf_count", bus.count, 4);
    check("ovf_full",  bus.full, 1);
    check("ovf_drop",  bus.wr_drop, 1);
    drain();

    // Wrap-around streaming
    written = 0;
    n = 0;
    while (written < 10 && n < 500) begin
      if (mq.size() < DEPTH - 1) begin
        step(1'b1, 8'h40 + 8'(written), 1'b1);
        written++;
      end else begin
        step(1'b0, 8'h00, 1'b1);
      end
      n++;
    end
    check("wrap_timeout", (n < 500) ? 1 : 0, 1);
    drain();

    // tx_en dropped during SEND
    step(1'b1, 8'h71, 1'b1);
    step(1'b1, 8'h72, 1'b1);
    step(1'b1, 8'h73, 1'b1);
    n = 0;
    while (!bus.valid && n < 20) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("send_seen", bus.valid, 1);
    repeat (20) step(1'b0, 8'h00, 1'b0);
    check("held_count", bus.count, 2);
    drain();

    // Reset during WAIT with bytes queued
    step(1'b1, 8'h81, 1'b1);
    step(1'b1, 8'h82, 1'b1);
    step(1'b1, 8'h83, 1'b1);
    step(1'b1, 8'h84, 1'b1);
    n = 0;
    while (!(busy > 0 && busy <= FC - VC) && n < 20) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("wait_seen", (n < 20) ? 1 : 0, 1);
    check("queued3", bus.count, 3);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mrst_valid", bus.valid, 0);
    check("mrst_data",  bus.data_in, 0);
    check("mrst_count", bus.count, 0);
    check("mrst_empty", bus.empty, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h9C, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
